window_3x3_generator: RTL and testbench

//  Streaming 3x3 window source that drives the atmospheric light estimation stage's input_valid/input_pixel_1..9 interface.

---
 rtl/window_3x3_generator_if.sv | 35 +++
 rtl/window_3x3_generator.sv | 132 +++++++++++++
 tb/tb_window_3x3_generator.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/window_3x3_generator_if.sv
// rtl/window_3x3_generator_if.sv - pixel stream in, 3x3 window stream out
interface window_3x3_generator_if #(
    parameter int PIXEL_W = 24
);
    logic               pixel_valid;
    logic [PIXEL_W-1:0] pixel_in;
    logic               input_ready;
    logic               window_valid;
    logic [PIXEL_W-1:0] window_pixel_1;
    logic [PIXEL_W-1:0] window_pixel_2;
    logic [PIXEL_W-1:0] window_pixel_3;
    logic [PIXEL_W-1:0] window_pixel_4;
    logic [PIXEL_W-1:0] window_pixel_5;
    logic [PIXEL_W-1:0] window_pixel_6;
    logic [PIXEL_W-1:0] window_pixel_7;
    logic [PIXEL_W-1:0] window_pixel_8;
    logic [PIXEL_W-1:0] window_pixel_9;
    logic               frame_done;

    modport master (
        output pixel_valid, pixel_in,
        input  input_ready, window_valid, frame_done,
        input  window_pixel_1, window_pixel_2, window_pixel_3,
        input  window_pixel_4, window_pixel_5, window_pixel_6,
        input  window_pixel_7, window_pixel_8, window_pixel_9
    );

    modport slave (
        input  pixel_valid, pixel_in,
        output input_ready, window_valid, frame_done,
        output window_pixel_1, window_pixel_2, window_pixel_3,
        output window_pixel_4, window_pixel_5, window_pixel_6,
        output window_pixel_7, window_pixel_8, window_pixel_9
    );
endinterface

// File: rtl/window_3x3_generator.sv
// rtl/window_3x3_generator.sv - replicated-border 3x3 window generator over a two-line history
module window_3x3_generator #(
    parameter int WIDTH   = 512,
    parameter int HEIGHT  = 512,
    parameter int PIXEL_W = 24
) (
    input  logic                  clk,
    input  logic                  rst,
    window_3x3_generator_if.slave bus
);
    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int TAPS  = 2 * WIDTH + 3;
    localparam int IDX_W = $clog2(NPIX);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);

    typedef enum logic [1:0] {FILL, STREAM, FLUSH, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   in_idx;
    logic [COL_W-1:0]   cx;
    logic [ROW_W-1:0]   cy;
    logic               window_valid_q;
    logic               frame_done_q;
    logic [PIXEL_W-1:0] win_q [0:8];
    logic [PIXEL_W-1:0] win_d [0:8];
    logic [PIXEL_W-1:0] hist  [0:TAPS-2];
    logic [PIXEL_W-1:0] taps  [0:TAPS-1];
    logic               accept;
    logic               emit;
    logic               step;

    assign bus.input_ready = (state == FILL) || (state == STREAM);
    assign accept = bus.pixel_valid && bus.input_ready && !rst;
    assign emit   = (state == FLUSH) || ((state == STREAM) && accept);
    // Flush cycles shift a don't-care pixel so the centre keeps its tap; clamping never reads it.
    assign step   = accept || (state == FLUSH);

    always_ff @(posedge clk) begin
        if (step) begin
            hist[0] <= bus.pixel_in;
            for (int i = 1; i < TAPS - 1; i++) hist[i] <= hist[i-1];
        end
    end

    always_comb begin
        taps[0] = bus.pixel_in;
        for (int i = 1; i < TAPS; i++) taps[i] = hist[i-1];
    end

    logic top, bot, left, right;
    assign top   = (cy == '0);
    assign bot   = (cy == ROW_W'(HEIGHT - 1));
    assign left  = (cx == '0);
    assign right = (cx == COL_W'(WIDTH - 1));

    // Centre sits at tap WIDTH+1; offset (dr,dc) lives at WIDTH+1-dr*WIDTH-dc.
    for (genvar rr = 0; rr < 3; rr++) begin : g_row
        for (genvar cc = 0; cc < 3; cc++) begin : g_col
            localparam int DR   = rr - 1;
            localparam int DC   = cc - 1;
            localparam int T00  = WIDTH + 1;
            localparam int T0C  = WIDTH + 1 - DC;
            localparam int TR0  = WIDTH + 1 - DR * WIDTH;
            localparam int TRC  = WIDTH + 1 - DR * WIDTH - DC;
            logic row_clamp, col_clamp;
            assign row_clamp = ((DR == -1) && top)  || ((DR == 1) && bot);
            assign col_clamp = ((DC == -1) && left) || ((DC == 1) && right);
            assign win_d[rr*3+cc] = row_clamp ? (col_clamp ? taps[T00] : taps[T0C])
                                              : (col_clamp ? taps[TR0] : taps[TRC]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= FILL;
            in_idx         <= '0;
            cx             <= '0;
            cy             <= '0;
            window_valid_q <= 1'b0;
            frame_done_q   <= 1'b0;
            for (int i = 0; i < 9; i++) win_q[i] <= '0;
        end else begin
            window_valid_q <= emit;
            frame_done_q   <= 1'b0;
            if (emit) begin
                for (int i = 0; i < 9; i++) win_q[i] <= win_d[i];
                if (right) begin
                    cx <= '0;
                    cy <= bot ? '0 : cy + ROW_W'(1);
                end else begin
                    cx <= cx + COL_W'(1);
                end
            end
            case (state)
                FILL: if (accept) begin
                    in_idx <= in_idx + IDX_W'(1);
                    if (in_idx == IDX_W'(WIDTH)) state <= STREAM;
                end
                STREAM: if (accept) begin
                    if (in_idx == IDX_W'(NPIX - 1)) begin
                        in_idx <= '0;
                        state  <= FLUSH;
                    end else begin
                        in_idx <= in_idx + IDX_W'(1);
                    end
                end
                FLUSH: if (right && bot) state <= DONE;
                DONE: begin
                    frame_done_q <= 1'b1;
                    in_idx       <= '0;
                    cx           <= '0;
                    cy           <= '0;
                    state        <= FILL;
                end
                default: state <= FILL;
            endcase
        end
    end

    assign bus.window_valid   = window_valid_q;
    assign bus.frame_done     = frame_done_q;
    assign bus.window_pixel_1 = win_q[0];
    assign bus.window_pixel_2 = win_q[1];
    assign bus.window_pixel_3 = win_q[2];
    assign bus.window_pixel_4 = win_q[3];
    assign bus.window_pixel_5 = win_q[4];
    assign bus.window_pixel_6 = win_q[5];
    assign bus.window_pixel_7 = win_q[6];
    assign bus.window_pixel_8 = win_q[7];
    assign bus.window_pixel_9 = win_q[8];
endmodule

// File: tb/tb_window_3x3_generator.sv
// tb/tb_window_3x3_generator.sv - directed 4x4 frames checked against a clamped-window model
module tb_window_3x3_generator;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;

    window_3x3_generator_if #(.PIXEL_W(24)) bus ();

    window_3x3_generator #(.WIDTH(4), .HEIGHT(4), .PIXEL_W(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    logic [215:0] win_log [0:127];
    int           win_cyc [0:127];
    int           nwin = 0;
    int           done_c  [0:7];
    int           ndone = 0;
    int           acc_e   [0:5][0:15];
    int           first_nr[0:5];

    always @(negedge clk) begin
        if (bus.window_valid && nwin < 128) begin
            win_log[nwin] = {bus.window_pixel_1, bus.window_pixel_2, bus.window_pixel_3,
                             bus.window_pixel_4, bus.window_pixel_5, bus.window_pixel_6,
                             bus.window_pixel_7, bus.window_pixel_8, bus.window_pixel_9};
            win_cyc[nwin] = cyc;
            nwin++;
        end
        if (bus.frame_done && ndone < 8) begin
            done_c[ndone] = cyc;
            ndone++;
        end
    end

    function automatic logic [215:0] expand(input logic [71:0] b);
        logic [215:0] w;
        for (int i = 0; i < 9; i++) w[i*24 +: 24] = {3{b[i*8 +: 8]}};
        return w;
    endfunction

    function automatic logic [215:0] model(input int j);
        logic [215:0] w;
        int r, c, rr, cc;
        r = j / 4;
        c = j % 4;
        for (int p = 0; p < 9; p++) begin
            rr = r + p / 3 - 1;
            cc = c + p % 3 - 1;
            if (rr < 0) rr = 0;
            if (rr > 3) rr = 3;
            if (cc < 0) cc = 0;
            if (cc > 3) cc = 3;
            w[(8-p)*24 +: 24] = {3{8'(rr * 4 + cc)}};
        end
        return w;
    endfunction

    task automatic chk_win(input string tag, input logic [215:0] obs, input logic [215:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.pixel_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic send(input logic [7:0] b, output int acc, output int nr);
        nr = 0;
        bus.pixel_valid = 1'b1;
        bus.pixel_in    = {3{b}};
        @(negedge clk);
        while (!bus.input_ready && nr < 50) begin
            nr++;
            @(negedge clk);
        end
        acc = cyc + 1;
        @(posedge clk); #1;
        bus.pixel_valid = 1'b0;
    endtask

    task automatic run_frame(input int f, input bit gaps, input int count);
        int nr;
        int acc;
        for (int k = 0; k < count; k++) begin
            if (gaps)
                for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) idle();
            send(8'(k), acc, nr);
            acc_e[f][k] = acc;
            if (k == 0) first_nr[f] = nr;
        end
    endtask

    task automatic wait_done(input int n);
        int g = 0;
        while (ndone < n && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk_int("frame_done_seen", ndone, n);
        @(posedge clk); #1;
    endtask

    task automatic check_frame(input int f, input int base, input int di);
        for (int j = 0; j < 16; j++) chk_win($sformatf("win_f%0d_c%0d", f, j), win_log[base+j], model(j));
        for (int j = 0; j < 11; j++) chk_int($sformatf("lat_f%0d_c%0d", f, j), win_cyc[base+j], acc_e[f][j+5]);
        chk_int("flush_back_to_back", win_cyc[base+15] - win_cyc[base+11], 4);
        chk_int("done_after_last", done_c[di], win_cyc[base+15] + 1);
        chk_win("first_centre0", win_log[base+0],  expand(72'h00_00_01_00_00_01_04_04_05));
        chk_win("interior_c5",   win_log[base+5],  expand(72'h00_01_02_04_05_06_08_09_0a));
        chk_win("right_edge_c7", win_log[base+7],  expand(72'h02_03_03_06_07_07_0a_0b_0b));
        chk_win("last_c15",      win_log[base+15], expand(72'h0a_0b_0b_0e_0f_0f_0e_0f_0f));
    endtask

    initial begin
        int base2, base4;
        bus.pixel_valid = 1'b0;
        bus.pixel_in    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_int("rst_window_valid", int'(bus.window_valid), 0);
        chk_int("rst_frame_done",   int'(bus.frame_done), 0);
        chk_int("rst_input_ready",  int'(bus.input_ready), 1);
        chk_win("rst_pixels", {bus.window_pixel_1, bus.window_pixel_2, bus.window_pixel_3,
                               bus.window_pixel_4, bus.window_pixel_5, bus.window_pixel_6,
                               bus.window_pixel_7, bus.window_pixel_8, bus.window_pixel_9}, '0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Two frames back to back: frame 1 pixel 0 is offered through FLUSH/DONE.
        run_frame(0, 1'b0, 16);
        run_frame(1, 1'b0, 16);
        chk_int("holdoff_cycles", first_nr[1], 6);
        wait_done(2);
        check_frame(0, 0, 0);
        check_frame(1, 16, 1);
        chk_int("strobes_two_frames", nwin, 32);

        base2 = nwin;
        run_frame(2, 1'b1, 16);
        wait_done(3);
        check_frame(2, base2, 2);
        chk_int("strobes_gap_frame", nwin - base2, 16);

        run_frame(3, 1'b0, 10);
        rst = 1'b1;
        @(negedge clk);
        chk_int("midrst_window_valid", int'(bus.window_valid), 0);
        chk_int("midrst_pixel_5", int'(bus.window_pixel_5), 0);
        chk_int("midrst_input_ready", int'(bus.input_ready), 1);
        @(posedge clk); #1;
        rst = 1'b0;
        base4 = nwin;
        run_frame(4, 1'b0, 16);
        wait_done(4);
        check_frame(4, base4, 3);
        chk_int("strobes_after_reset", nwin - base4, 16);
        chk_int("total_done_pulses", ndone, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
